// File: rtl/refclk_sw_ctrl.sv
// Reference clock switch controller: priority selection with holdoff,
// wait-to-restore, revertive return and manual force.
module refclk_sw_ctrl #(
    parameter int NUM_REF  = 11,
    parameter int NUM_CAND = 4,
    localparam int IDX_W   = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1
) (
    input  logic                     clk_125m,
    input  logic                     rst,
    input  logic                     tick_1ms,
    input  logic [NUM_REF-1:0]       clk_loss,
    input  logic [NUM_CAND-1:0][3:0] cfg_pri,
    input  logic [NUM_CAND-1:0]      cfg_pri_vld,
    input  logic                     cfg_revertive,
    input  logic [7:0]               cfg_holdoff_ms,
    input  logic [15:0]              cfg_wtr_ms,
    input  logic                     cfg_force_en,
    input  logic [IDX_W-1:0]         cfg_force_idx,
    output logic                     ref_en,
    output logic [3:0]               ref_sel,
    output logic [IDX_W-1:0]         sel_idx,
    output logic [2:0]               state,
    output logic                     sw_event
);

    typedef enum logic [2:0] {
        FREERUN = 3'd0,
        LOCKED  = 3'd1,
        HOLDOFF = 3'd2,
        WTR     = 3'd3,
        FORCED  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   sel_idx_q, sel_idx_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               sw_event_q, sw_event_d;
    logic [3:0]         ref_sel_q;
    logic               ref_en_q;

    logic [NUM_CAND-1:0] good;
    logic [IDX_W-1:0]    best;
    logic                best_vld;
    logic                higher_good;
    logic                cur_good;
    logic                hold_done;
    logic                wtr_done;

    // Ids at or beyond NUM_REF match no source and so are never good.
    always_comb begin
        good = '0;
        for (int k = 0; k < NUM_CAND; k++) begin
            for (int j = 0; j < NUM_REF; j++) begin
                if (cfg_pri_vld[k] && (cfg_pri[k] == 4'(j)) && !clk_loss[j]) begin
                    good[k] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        best_vld    = 1'b0;
        best        = '0;
        higher_good = 1'b0;
        for (int k = NUM_CAND - 1; k >= 0; k--) begin
            if (good[k]) begin
                best_vld = 1'b1;
                best     = IDX_W'(k);
            end
        end
        for (int k = 0; k < NUM_CAND; k++) begin
            if (good[k] && (k < int'(sel_idx_q))) begin
                higher_good = 1'b1;
            end
        end
    end

    assign cur_good  = good[sel_idx_q];
    assign hold_done = (cnt_q >= 16'(cfg_holdoff_ms));
    assign wtr_done  = (cnt_q >= cfg_wtr_ms);

    always_comb begin
        state_d    = state_q;
        sel_idx_d  = sel_idx_q;
        sw_event_d = 1'b0;
        if (cfg_force_en) begin
            state_d    = FORCED;
            sel_idx_d  = cfg_force_idx;
            sw_event_d = (cfg_force_idx != sel_idx_q);
        end else begin
            case (state_q)
                FREERUN: begin
                    if (best_vld) begin
                        state_d    = LOCKED;
                        sel_idx_d  = best;
                        sw_event_d = 1'b1;
                    end
                end
                LOCKED: begin
                    if (!cur_good) begin
                        state_d = HOLDOFF;
                    end else if (cfg_revertive && higher_good) begin
                        state_d = WTR;
                    end
                end
                HOLDOFF: begin
                    if (cur_good) begin
                        state_d = LOCKED;
                    end else if (hold_done) begin
                        if (best_vld) begin
                            state_d    = LOCKED;
                            sel_idx_d  = best;
                            sw_event_d = (best != sel_idx_q);
                        end else begin
                            state_d = FREERUN;
                        end
                    end
                end
                WTR: begin
                    if (!cur_good) begin
                        state_d = HOLDOFF;
                    end else if (!higher_good || !cfg_revertive) begin
                        state_d = LOCKED;
                    end else if (wtr_done) begin
                        state_d    = LOCKED;
                        sel_idx_d  = best;
                        sw_event_d = 1'b1;
                    end
                end
                FORCED: begin
                    state_d = FREERUN;
                end
                default: begin
                    state_d = FREERUN;
                end
            endcase
        end
    end

    // A tick landing on the transition edge is dropped with the clear.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (tick_1ms && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_125m) begin
        if (rst) begin
            state_q    <= FREERUN;
            sel_idx_q  <= '0;
            cnt_q      <= '0;
            sw_event_q <= 1'b0;
            ref_sel_q  <= '0;
            ref_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_idx_q  <= sel_idx_d;
            cnt_q      <= cnt_d;
            sw_event_q <= sw_event_d;
            ref_sel_q  <= cfg_pri[sel_idx_d];
            ref_en_q   <= (state_d != FREERUN);
        end
    end

    assign state    = state_q;
    assign sel_idx  = sel_idx_q;
    assign sw_event = sw_event_q;
    assign ref_sel  = ref_sel_q;
    assign ref_en   = ref_en_q;

endmodule

// File: tb/tb_refclk_sw_ctrl.sv
// Scoreboard bench for refclk_sw_ctrl: expected outputs are queued with
// each stimulus step and popped against the DUT after the clock edge.
module tb_refclk_sw_ctrl;

    logic            clk_125m = 1'b0;
    logic            rst;
    logic            tick_1ms;
    logic [10:0]     clk_loss;
    logic [3:0][3:0] cfg_pri;
    logic [3:0]      cfg_pri_vld;
    logic            cfg_revertive;
    logic [7:0]      cfg_holdoff_ms;
    logic [15:0]     cfg_wtr_ms;
    logic            cfg_force_en;
    logic [1:0]      cfg_force_idx;
    logic            ref_en;
    logic [3:0]      ref_sel;
    logic [1:0]      sel_idx;
    logic [2:0]      state;
    logic            sw_event;

    typedef struct {
        string      tag;
        logic [2:0] st;
        logic [1:0] idx;
        logic [3:0] sel;
        logic       en;
        logic       sw;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   ev_cnt = 0;
    int   ev_exp = 0;

    refclk_sw_ctrl dut (
        .clk_125m       (clk_125m),
        .rst            (rst),
        .tick_1ms       (tick_1ms),
        .clk_loss       (clk_loss),
        .cfg_pri        (cfg_pri),
        .cfg_pri_vld    (cfg_pri_vld),
        .cfg_revertive  (cfg_revertive),
        .cfg_holdoff_ms (cfg_holdoff_ms),
        .cfg_wtr_ms     (cfg_wtr_ms),
        .cfg_force_en   (cfg_force_en),
        .cfg_force_idx  (cfg_force_idx),
        .ref_en         (ref_en),
        .ref_sel        (ref_sel),
        .sel_idx        (sel_idx),
        .state          (state),
        .sw_event       (sw_event)
    );

    always #4 clk_125m = ~clk_125m;

    always @(negedge clk_125m) begin
        if (sw_event) ev_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [2:0] st,
                        input logic [1:0] idx, input logic [3:0] sel,
                        input logic en, input logic sw);
        exp_t e;
        e.tag = tag;
        e.st  = st;
        e.idx = idx;
        e.sel = sel;
        e.en  = en;
        e.sw  = sw;
        sb.push_back(e);
        if (sw) ev_exp++;
    endtask

    task automatic sb_check();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.tag, ".state"}, 32'(state),    32'(e.st));
            chk({e.tag, ".idx"},   32'(sel_idx),  32'(e.idx));
            chk({e.tag, ".sel"},   32'(ref_sel),  32'(e.sel));
            chk({e.tag, ".en"},    32'(ref_en),   32'(e.en));
            chk({e.tag, ".sw"},    32'(sw_event), 32'(e.sw));
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_125m);
        #1;
    endtask

    task automatic tick_ms(input int n);
        for (int i = 0; i < n; i++) begin
            tick_1ms = 1'b1;
            step(1);
            tick_1ms = 1'b0;
            step(1);
        end
    endtask

    initial begin
        rst            = 1'b1;
        tick_1ms       = 1'b0;
        clk_loss       = '0;
        cfg_pri[0]     = 4'd3;
        cfg_pri[1]     = 4'd5;
        cfg_pri[2]     = 4'd7;
        cfg_pri[3]     = 4'd9;
        cfg_pri_vld    = 4'hF;
        cfg_revertive  = 1'b0;
        cfg_holdoff_ms = 8'd5;
        cfg_wtr_ms     = 16'd10;
        cfg_force_en   = 1'b0;
        cfg_force_idx  = 2'd0;
        step(3);
        push("reset", 3'd0, 2'd0, 4'd0, 1'b0, 1'b0);
        sb_check();

        rst = 1'b0;
        push("first_sel", 3'd1, 2'd0, 4'd3, 1'b1, 1'b1);
        step(1);
        sb_check();

        clk_loss[3] = 1'b1;
        push("ho_enter", 3'd2, 2'd0, 4'd3, 1'b1, 1'b0);
        step(1);
        sb_check();
        tick_ms(3);
        clk_loss[3] = 1'b0;
        push("ho_recover", 3'd1, 2'd0, 4'd3, 1'b1, 1'b0);
        step(1);
        sb_check();

        clk_loss[3] = 1'b1;
        step(1);
        tick_ms(4);
        push("ho_tick4", 3'd2, 2'd0, 4'd3, 1'b1, 1'b0);
        sb_check();
        tick_ms(1);
        push("ho_switch", 3'd1, 2'd1, 4'd5, 1'b1, 1'b1);
        sb_check();

        cfg_revertive = 1'b1;
        clk_loss[3]   = 1'b0;
        push("wtr_enter", 3'd3, 2'd1, 4'd5, 1'b1, 1'b0);
        step(1);
        sb_check();
        tick_ms(9);
        push("wtr_tick9", 3'd3, 2'd1, 4'd5, 1'b1, 1'b0);
        sb_check();
        tick_ms(1);
        push("wtr_revert", 3'd1, 2'd0, 4'd3, 1'b1, 1'b1);
        sb_check();

        cfg_revertive  = 1'b0;
        cfg_holdoff_ms = 8'd0;
        clk_loss[3]    = 1'b1;
        push("ho0_enter", 3'd2, 2'd0, 4'd3, 1'b1, 1'b0);
        step(1);
        sb_check();
        push("ho0_switch", 3'd1, 2'd1, 4'd5, 1'b1, 1'b1);
        step(1);
        sb_check();
        clk_loss[3] = 1'b0;
        step(1);
        tick_ms(12);
        push("nonrev_stay", 3'd1, 2'd1, 4'd5, 1'b1, 1'b0);
        sb_check();

        clk_loss = 11'b010_1010_1000;
        push("all_lost_ho", 3'd2, 2'd1, 4'd5, 1'b1, 1'b0);
        step(1);
        sb_check();
        push("all_lost_fr", 3'd0, 2'd1, 4'd5, 1'b0, 1'b0);
        step(1);
        sb_check();
        cfg_force_en  = 1'b1;
        cfg_force_idx = 2'd2;
        push("force_enter", 3'd4, 2'd2, 4'd7, 1'b1, 1'b1);
        step(1);
        sb_check();
        cfg_force_idx = 2'd3;
        push("force_idx", 3'd4, 2'd3, 4'd9, 1'b1, 1'b1);
        step(1);
        sb_check();
        cfg_force_en = 1'b0;
        clk_loss[7]  = 1'b0;
        push("force_off", 3'd0, 2'd3, 4'd9, 1'b0, 1'b0);
        step(1);
        sb_check();
        push("force_resel", 3'd1, 2'd2, 4'd7, 1'b1, 1'b1);
        step(1);
        sb_check();

        clk_loss      = '0;
        cfg_revertive = 1'b1;
        cfg_wtr_ms    = 16'd0;
        push("wtr0_enter", 3'd3, 2'd2, 4'd7, 1'b1, 1'b0);
        step(1);
        sb_check();
        push("wtr0_revert", 3'd1, 2'd0, 4'd3, 1'b1, 1'b1);
        step(1);
        sb_check();

        cfg_revertive = 1'b0;
        cfg_pri[0]    = 4'd12;
        push("bad_id_ho", 3'd2, 2'd0, 4'd12, 1'b1, 1'b0);
        step(1);
        sb_check();
        push("bad_id_sw", 3'd1, 2'd1, 4'd5, 1'b1, 1'b1);
        step(1);
        sb_check();

        cfg_pri[0] = 4'd3;
        step(1);
        cfg_revertive = 1'b1;
        cfg_wtr_ms    = 16'd10;
        push("wtr2_enter", 3'd3, 2'd1, 4'd5, 1'b1, 1'b0);
        step(1);
        sb_check();
        tick_ms(6);
        push("wtr2_tick6", 3'd3, 2'd1, 4'd5, 1'b1, 1'b0);
        sb_check();
        rst = 1'b1;
        push("rst_mid_wtr", 3'd0, 2'd0, 4'd0, 1'b0, 1'b0);
        step(1);
        sb_check();
        rst = 1'b0;
        push("rst_resel", 3'd1, 2'd0, 4'd3, 1'b1, 1'b1);
        step(1);
        sb_check();

        step(3);
        chk("ev_total", 32'(ev_cnt), 32'(ev_exp));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/refclk_sw_ctrl.md
REFCLK_SW_CTRL -- requirements
Module: refclk_sw_ctrl

Interface
REQ-001 SHALL have parameter NUM_REF, 11, number of reference clock sources monitored by clk_loss.
REQ-002 SHALL have parameter NUM_CAND, 4, number of priority-ordered candidates; index 0 is the highest priority.
REQ-003 SHALL have port clk_125m  in  1  the only clock.
REQ-004 SHALL have port rst  in  1  reset, synchronous to clk_125m, active-high.
REQ-005 SHALL have port tick_1ms  in  1  single-cycle 1 kHz strobe (clk_1k_fp).
REQ-006 SHALL have port clk_loss  in  NUM_REF  per-source loss flag, 1 = lost.
REQ-007 SHALL have port cfg_pri  in  NUM_CAND x 4  source id per candidate.
REQ-008 SHALL have port cfg_pri_vld  in  NUM_CAND  candidate enable.
REQ-009 SHALL have port cfg_revertive  in  1  1 = return to a higher-priority source after WTR.
REQ-010 SHALL have port cfg_holdoff_ms  in  8  holdoff time in ms.
REQ-011 SHALL have port cfg_wtr_ms  in  16  wait-to-restore time in ms.
REQ-012 SHALL have port cfg_force_en  in  1  manual selection override.
REQ-013 SHALL have port cfg_force_idx  in  2  candidate index used when forced.
REQ-014 SHALL have port ref_en  out  1  drives the selector enable of the clock mux.
REQ-015 SHALL have port ref_sel  out  4  drives the selector code of the clock mux.
REQ-016 SHALL have port sel_idx  out  2  active candidate index.
REQ-017 SHALL have port state  out  3  FSM state code.
REQ-018 SHALL have port sw_event  out  1  one-cycle pulse on every selection change.

Function
REQ-019 SHALL treat candidate k as good when all of these hold: cfg_pri_vld[k]=1, cfg_pri[k]<=NUM_REF-1, and clk_loss[cfg_pri[k]]=0; an id greater than 10 SHALL never be good.
REQ-020 SHALL define best as the lowest-index good candidate, and SHALL define higher-good as any good candidate with an index lower than sel_idx.
REQ-021 SHALL encode states as FREERUN=0, LOCKED=1, HOLDOFF=2, WTR=3, FORCED=4; all other codes SHALL go to FREERUN on the next cycle.
REQ-022 In FREERUN, if best exists, the FSM SHALL load sel_idx=best, enter LOCKED and pulse sw_event; otherwise it SHALL stay in FREERUN.
REQ-023 In LOCKED, if the current candidate is not good, the FSM SHALL enter HOLDOFF; otherwise, if cfg_revertive=1 and higher-good exists, it SHALL enter WTR.
REQ-024 In HOLDOFF, if the current candidate is good again, the FSM SHALL return to LOCKED with no switch and no sw_event.
REQ-025 In HOLDOFF, when cnt>=cfg_holdoff_ms, the FSM SHALL select best, enter LOCKED and pulse sw_event if sel_idx changes; if no best exists it SHALL enter FREERUN.
REQ-026 In WTR, loss of the current candidate SHALL take precedence and the FSM SHALL enter HOLDOFF.
REQ-027 In WTR, if higher-good disappears or cfg_revertive=0, the FSM SHALL return to LOCKED.
REQ-028 In WTR, when cnt>=cfg_wtr_ms, the FSM SHALL load sel_idx=best, enter LOCKED and pulse sw_event.
REQ-029 cfg_force_en=1 SHALL override every state: the FSM enters FORCED with sel_idx=cfg_force_idx and ref_en=1, regardless of loss and of cfg_pri_vld.
REQ-030 sw_event SHALL pulse on entry to FORCED when sel_idx changes, and on any cfg_force_idx change while in FORCED.
REQ-031 Deassertion of cfg_force_en SHALL move the FSM to FREERUN, and reselection SHALL occur on the following cycle.
REQ-032 cnt SHALL be 16 bits, cleared on every state entry, and incremented only on tick_1ms; it SHALL saturate at 0xFFFF.
REQ-033 A tick_1ms in the entry cycle of a state SHALL not be counted.
REQ-034 cfg_holdoff_ms=0 or cfg_wtr_ms=0 SHALL cause the transition on the cycle after entry.
REQ-035 All outputs SHALL be registered; a clk_loss edge SHALL change state one cycle later.
REQ-036 ref_sel SHALL equal cfg_pri[sel_idx], re-registered every cycle, so a cfg_pri change takes effect one cycle later.
REQ-037 ref_en SHALL be 0 in FREERUN and 1 in all other states.
REQ-038 tick_1ms coinciding with any clk_loss change SHALL be handled as if clk_loss were evaluated first.

Reset
REQ-039 While rst=1, the block SHALL hold state=FREERUN, sel_idx=0, ref_sel=0, ref_en=0, sw_event=0 and cnt=0.
REQ-040 Assertion of rst mid-HOLDOFF or mid-WTR SHALL abandon the timer, with no sw_event.
REQ-041 After rst deasserts, the first selection SHALL occur on the next cycle per REQ-022.

Verification
REQ-042 Stimulus: pri={3,5,7,9} all valid, no loss, release rst. Response: one cycle later state=1, sel_idx=0, ref_sel=3, ref_en=1, one sw_event.
REQ-043 Stimulus: holdoff=5, assert clk_loss[3]. Response: HOLDOFF; after the 5th tick, sel_idx=1, ref_sel=5, sw_event.
REQ-044 Stimulus: holdoff=5, clk_loss[3] asserted then cleared after 3 ticks. Response: LOCKED, sel_idx=0, no sw_event.
REQ-045 Stimulus: revertive=1, wtr=10, on candidate 1, clear loss on source 3. Response: WTR; after 10 ticks, ref_sel=3, sw_event. Stimulus: same with revertive=0. Response: stays on ref_sel=5.
REQ-046 Stimulus: all four sources lost, holdoff=0. Response: FREERUN, ref_en=0 within 2 cycles. Then force_en=1, force_idx=2. Response: FORCED, ref_sel=7, ref_en=1.
REQ-047 Stimulus: rst pulse at WTR count 6. Response: FREERUN with all outputs zero, then reselection of best on the next cycle.
